execute_stage: RTL

//  Execute stage of the 5-stage pipeline; sits between the decode/execute register and the memory stage.
//  - Operand forwarding, ALU and ARM-style condition check.
//  - Owns the architectural NZCV flags register.
//  - Registers the gated results into the execute/memory pipeline boundary (outputs *M).

---
 rtl/pipe_pkg.sv | 62 ++++++
 rtl/execute_stage_if.sv | 39 +++
 rtl/execute_stage_alu.sv | 56 +++++
 rtl/execute_stage.sv | 102 ++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared encodings for the execute stage: ALU ops, ARM condition
//            codes, forwarding selects and the condition-check helper.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_ORR = 4'd3,
    ALU_EOR = 4'd4,
    ALU_MOV = 4'd5,
    ALU_MVN = 4'd6,
    ALU_LSL = 4'd7,
    ALU_LSR = 4'd8
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  typedef enum logic [1:0] {
    FWD_RD   = 2'b00,
    FWD_RESW = 2'b01,
    FWD_ALUM = 2'b10
  } fwd_sel_e;

  // nzcv packed as {N,Z,C,V}; the reserved 1111 code never executes
  function automatic logic cond_pass(input cond_e cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/execute_stage_if.sv
// ============================================================================
// Module   : execute_stage_if
// Purpose  : Decode/execute inputs and execute/memory outputs of the stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface execute_stage_if #(parameter int DW = 32);

  logic [DW-1:0] RD1E, RD2E, ExtImmE, ResultW;
  logic [3:0]    CondE, ALUControlE, WA3E;
  logic          PCSrcE, BranchE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE;
  logic [1:0]    FlagWriteE, ForwardAE, ForwardBE;
  logic          FlushE;

  logic          CondExE, BranchTakenE;
  logic [DW-1:0] ALUResultE, ALUResultM, WriteDataM;
  logic [3:0]    FlagsQ, WA3M;
  logic          PCSrcM, RegWriteM, MemtoRegM, MemWriteM;

  modport master (
    output RD1E, RD2E, ExtImmE, ResultW, CondE, ALUControlE, WA3E,
           PCSrcE, BranchE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE,
           FlagWriteE, ForwardAE, ForwardBE, FlushE,
    input  CondExE, BranchTakenE, ALUResultE, ALUResultM, WriteDataM,
           FlagsQ, WA3M, PCSrcM, RegWriteM, MemtoRegM, MemWriteM
  );

  modport slave (
    input  RD1E, RD2E, ExtImmE, ResultW, CondE, ALUControlE, WA3E,
           PCSrcE, BranchE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE,
           FlagWriteE, ForwardAE, ForwardBE, FlushE,
    output CondExE, BranchTakenE, ALUResultE, ALUResultM, WriteDataM,
           FlagsQ, WA3M, PCSrcM, RegWriteM, MemtoRegM, MemWriteM
  );

endinterface

`default_nettype wire

// File: rtl/execute_stage_alu.sv
// ============================================================================
// Module   : alu
// Purpose  : Combinational ALU producing a result and its NZCV flags.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu
  import pipe_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [3:0]    op_i,
  output logic [DW-1:0] result_o,
  output logic [3:0]    nzcv_o
);

  logic          is_sub;
  logic [DW-1:0] b_eff;
  logic [DW:0]   sum;
  logic          carry, ovf;

  // SUB is A + ~B + 1 so carry-out means "no borrow"
  assign is_sub = (alu_op_e'(op_i) == ALU_SUB);
  assign b_eff  = is_sub ? ~b_i : b_i;
  assign sum    = {1'b0, a_i} + {1'b0, b_eff} + {{DW{1'b0}}, is_sub};
  assign ovf    = (a_i[DW-1] == b_eff[DW-1]) && (sum[DW-1] != a_i[DW-1]);
  assign carry  = sum[DW];

  always_comb begin
    result_o = '0;
    nzcv_o   = '0;
    case (alu_op_e'(op_i))
      ALU_ADD, ALU_SUB: begin
        result_o  = sum[DW-1:0];
        nzcv_o[1] = carry;
        nzcv_o[0] = ovf;
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_ORR: result_o = a_i | b_i;
      ALU_EOR: result_o = a_i ^ b_i;
      ALU_MOV: result_o = b_i;
      ALU_MVN: result_o = ~b_i;
      ALU_LSL: result_o = a_i << b_i[4:0];
      ALU_LSR: result_o = a_i >> b_i[4:0];
      default: result_o = '0;
    endcase
    nzcv_o[3] = result_o[DW-1];
    nzcv_o[2] = (result_o == '0);
  end

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// ============================================================================
// Module   : execute_stage
// Purpose  : Operand forwarding, ALU, condition check, NZCV flags register
//            and the execute/memory pipeline register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module execute_stage
  import pipe_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic           CLK,
  input  logic           RST,
  execute_stage_if.slave bus
);

  logic [DW-1:0] src_a, src_b, write_data_e, alu_result;
  logic [3:0]    alu_nzcv;
  logic          cond_ex, commit;

  logic [3:0]    flags_q, flags_d;
  logic [DW-1:0] alu_result_m_q, write_data_m_q;
  logic [3:0]    wa3_m_q;
  logic          pcsrc_m_q, regwrite_m_q, memtoreg_m_q, memwrite_m_q;

  always_comb begin
    src_a = bus.RD1E;
    case (fwd_sel_e'(bus.ForwardAE))
      FWD_RESW: src_a = bus.ResultW;
      FWD_ALUM: src_a = alu_result_m_q;
      default:  src_a = bus.RD1E;
    endcase
  end

  // store data always follows the forwarded register, never the immediate
  always_comb begin
    write_data_e = bus.RD2E;
    case (fwd_sel_e'(bus.ForwardBE))
      FWD_RESW: write_data_e = bus.ResultW;
      FWD_ALUM: write_data_e = alu_result_m_q;
      default:  write_data_e = bus.RD2E;
    endcase
  end

  assign src_b = bus.ALUSrcE ? bus.ExtImmE : write_data_e;

  alu #(.DW(DW)) u_alu (
    .a_i      (src_a),
    .b_i      (src_b),
    .op_i     (bus.ALUControlE),
    .result_o (alu_result),
    .nzcv_o   (alu_nzcv)
  );

  assign cond_ex = cond_pass(cond_e'(bus.CondE), flags_q);
  assign commit  = cond_ex & ~bus.FlushE;

  always_comb begin
    flags_d = flags_q;
    if (bus.FlagWriteE[1] && commit) flags_d[3:2] = alu_nzcv[3:2];
    if (bus.FlagWriteE[0] && commit) flags_d[1:0] = alu_nzcv[1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flags_q        <= '0;
      alu_result_m_q <= '0;
      write_data_m_q <= '0;
      wa3_m_q        <= '0;
      pcsrc_m_q      <= 1'b0;
      regwrite_m_q   <= 1'b0;
      memtoreg_m_q   <= 1'b0;
      memwrite_m_q   <= 1'b0;
    end else begin
      flags_q        <= flags_d;
      alu_result_m_q <= alu_result;
      write_data_m_q <= write_data_e;
      wa3_m_q        <= bus.WA3E;
      pcsrc_m_q      <= bus.PCSrcE & commit;
      regwrite_m_q   <= bus.RegWriteE & commit;
      memtoreg_m_q   <= bus.MemtoRegE & ~bus.FlushE;
      memwrite_m_q   <= bus.MemWriteE & commit;
    end
  end

  assign bus.CondExE      = cond_ex;
  assign bus.BranchTakenE = (bus.PCSrcE | bus.BranchE) & commit;
  assign bus.ALUResultE   = alu_result;
  assign bus.FlagsQ       = flags_q;
  assign bus.ALUResultM   = alu_result_m_q;
  assign bus.WriteDataM   = write_data_m_q;
  assign bus.WA3M         = wa3_m_q;
  assign bus.PCSrcM       = pcsrc_m_q;
  assign bus.RegWriteM    = regwrite_m_q;
  assign bus.MemtoRegM    = memtoreg_m_q;
  assign bus.MemWriteM    = memwrite_m_q;

endmodule

`default_nettype wire
